// File: rtl/mc_risk_pkg.sv
// Shared types and helpers for the Monte Carlo path engine.
// Helpers run at a fixed wide width so that any parameterisation can share them.
package mc_risk_pkg;

  typedef enum logic [1:0] {IDLE, STEP, ACCUM, DONE} state_t;

  localparam int DEF_W    = 18;
  localparam int DEF_FRAC = 12;
  // Working width of the helpers; must hold 3*W+2 bits of the step sum.
  localparam int FW       = 128;

  function automatic logic [FW-1:0] sat_add(input logic [FW-1:0] a,
                                            input logic [FW-1:0] b,
                                            input int            w);
    logic [FW-1:0] lim, sum;
    lim = (FW'(1) << w) - FW'(1);
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

  function automatic logic [FW-1:0] clamp_s(input logic signed [FW-1:0] x,
                                            input int                   w);
    logic signed [FW-1:0] lim;
    lim = (FW'(1) << (w - 1)) - FW'(1);
    if (x[FW-1]) return '0;
    if (x > lim) return lim;
    return x;
  endfunction

endpackage

// File: rtl/mc_path_accumulator_gbm_step.sv
// One GBM price step: S + (S*mu>>>F) + (((S*sigma>>>F)*eps)>>>F), clamped to [0, 2^(W-1)-1].
module gbm_step
  import mc_risk_pkg::*;
#(
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic signed [W-1:0] s,
  input  logic signed [W-1:0] mu,
  input  logic signed [W-1:0] sigma,
  input  logic signed [W-1:0] eps,
  output logic signed [W-1:0] s_next
);

  logic signed [2*W-1:0]   p_mu, p_sig, drift, vol;
  logic signed [3*W-1:0]   p_eps, diff;
  logic signed [3*W+1:0]   sum;
  logic signed [FW-1:0]    sum_w;
  logic        [FW-1:0]    clamped;

  assign p_mu  = (2*W)'(s) * (2*W)'(mu);
  assign p_sig = (2*W)'(s) * (2*W)'(sigma);
  assign drift = p_mu >>> FRAC;
  assign vol   = p_sig >>> FRAC;
  assign p_eps = (3*W)'(vol) * (3*W)'(eps);
  assign diff  = p_eps >>> FRAC;

  // Clamp once, on the fully widened sum, so no intermediate wraps.
  assign sum     = (3*W+2)'(drift) + (3*W+2)'(diff) + (3*W+2)'(s);
  assign sum_w   = FW'(sum);
  assign clamped = clamp_s(sum_w, W);
  assign s_next  = clamped[W-1:0];

  wire unused_hi = &{1'b0, clamped[FW-1:W]};

endmodule

// File: rtl/mc_path_accumulator.sv
// Monte Carlo GBM path engine: runs NUM_PATHS paths of NUM_STEPS eps-driven steps and
// accumulates saturated sum and sum-of-squares of the terminal prices.
module mc_path_accumulator
  import mc_risk_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int FRAC      = DEF_FRAC,
  parameter int ACC_W     = 27,
  parameter int NUM_PATHS = 4,
  parameter int NUM_STEPS = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                iStart,
  input  logic signed [W-1:0] iMu,
  input  logic signed [W-1:0] iSigma,
  input  logic signed [W-1:0] iS,
  input  logic signed [W-1:0] iEps,
  input  logic                iEpsValid,
  output logic                oEpsReady,
  output logic                oBusy,
  output logic                oDone,
  output logic [ACC_W-1:0]    oAcc1,
  output logic [ACC_W-1:0]    oAcc2
);

  localparam int SC_W = $clog2(NUM_STEPS + 1);
  localparam int PC_W = $clog2(NUM_PATHS + 1);

  state_t              state;
  logic signed [W-1:0] s, s_next, mu_r, sigma_r, s0_r;
  logic [SC_W-1:0]     step_cnt;
  logic [PC_W-1:0]     path_cnt;

  logic signed [2*W-1:0] sq;
  logic [FW-1:0]         acc1_sum, acc2_sum;
  logic                  hs;

  gbm_step #(.W(W), .FRAC(FRAC)) u_step (
    .s      (s),
    .mu     (mu_r),
    .sigma  (sigma_r),
    .eps    (iEps),
    .s_next (s_next)
  );

  // Price is never negative after a step, so the square and the adds stay unsigned.
  assign sq       = ((2*W)'(s) * (2*W)'(s)) >>> FRAC;
  assign acc1_sum = sat_add(FW'(oAcc1), FW'($unsigned(s)), ACC_W);
  assign acc2_sum = sat_add(FW'(oAcc2), FW'($unsigned(sq)), ACC_W);
  assign hs       = iEpsValid & oEpsReady;

  wire unused_hi = &{1'b0, acc1_sum[FW-1:ACC_W], acc2_sum[FW-1:ACC_W]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      s         <= '0;
      mu_r      <= '0;
      sigma_r   <= '0;
      s0_r      <= '0;
      step_cnt  <= '0;
      path_cnt  <= '0;
      oEpsReady <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oAcc1     <= '0;
      oAcc2     <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: if (iStart) begin
          mu_r      <= iMu;
          sigma_r   <= iSigma;
          s0_r      <= iS;
          s         <= iS;
          oAcc1     <= '0;
          oAcc2     <= '0;
          step_cnt  <= '0;
          path_cnt  <= '0;
          oEpsReady <= 1'b1;
          oBusy     <= 1'b1;
          state     <= STEP;
        end
        STEP: if (hs) begin
          s        <= s_next;
          step_cnt <= step_cnt + SC_W'(1);
          if (step_cnt == SC_W'(NUM_STEPS - 1)) begin
            oEpsReady <= 1'b0;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          oAcc1    <= acc1_sum[ACC_W-1:0];
          oAcc2    <= acc2_sum[ACC_W-1:0];
          path_cnt <= path_cnt + PC_W'(1);
          if (path_cnt == PC_W'(NUM_PATHS - 1)) begin
            oDone <= 1'b1;
            state <= DONE;
          end else begin
            s         <= s0_r;
            step_cnt  <= '0;
            oEpsReady <= 1'b1;
            state     <= STEP;
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mc_path_accumulator.md
# mc_path_accumulator

Parametrised Monte Carlo path engine for the risk-calculation pipeline. On a start pulse from option calculation, it simulates NUM_PATHS discrete geometric-Brownian price paths of NUM_STEPS steps each. Gaussian samples come from an external generator through a valid/ready handshake. The block reports the saturated sum and sum-of-squares of the terminal prices for downstream mean/variance (VaR) computation. It generalises the fixed single-shot accumulator to configurable width, fraction, path count and step count, and adds stall-tolerant sample intake and a busy/done protocol.

## Interface
- W, 18: signed fixed-point width of price, mu, sigma and eps.
- FRAC, 12: fractional bits (Q(W-FRAC).FRAC); 4096 represents 1.0.
- ACC_W, 27: accumulator width (unsigned).
- NUM_PATHS, 4: paths per run, ≥1.
- NUM_STEPS, 2: steps per path, ≥1.

- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- iStart  in  1  one-cycle start pulse (from option-calc done).
- iMu  in  W  drift per step, signed.
- iSigma  in  W  volatility per step, signed.
- iS  in  W  initial price, signed, expected ≥0.
- iEps  in  W  standard-normal sample, signed.
- iEpsValid  in  1  iEps valid.
- oEpsReady  out  1  engine accepts iEps this cycle.
- oBusy  out  1  run in progress.
- oDone  out  1  one-cycle pulse: run complete, accumulators final.
- oAcc1  out  ACC_W  Σ terminal price.
- oAcc2  out  ACC_W  Σ (terminal price² >>> FRAC).

## Operation
- States: IDLE, STEP, ACCUM, DONE.
- IDLE: iStart=1 → latch iMu/iSigma/iS, load S←iS, clear oAcc1/oAcc2 and counters, go to STEP.
- STEP: oEpsReady=1. On iEpsValid&oEpsReady:
  - drift = (S·mu)>>>FRAC
  - diff = (((S·sigma)>>>FRAC)·eps)>>>FRAC
  - S ← clamp(S+drift+diff, 0, 2^(W-1)-1)
  - step count increments.
  - Last step accepted → ACCUM.
  - No handshake → hold all state.
- Arithmetic: full-precision signed products; arithmetic shift (floor); clamp applied once on the widened sum.
- ACCUM:
  - oAcc1 ← sat(oAcc1+S)
  - oAcc2 ← sat(oAcc2 + (S·S>>>FRAC))
  - Saturation ceiling is 2^ACC_W-1.
  - Path count increments.
  - Last path → DONE; otherwise S←latched iS, step count←0, → STEP.
- DONE: oDone=1 for one cycle, → IDLE. Accumulators hold until the next accepted start.
- iStart outside IDLE is ignored. Inputs iMu/iSigma/iS are sampled only at start.
- oBusy=1 in STEP, ACCUM and DONE.
- Reset values: state IDLE. All outputs 0, including oEpsReady, oBusy, oDone, oAcc1, oAcc2. Reset mid-run aborts with no partial results retained.

## Timing
- Start accepted on edge t0 → STEP from t0+1.
- Each step consumes exactly one handshake cycle; eps stalls add cycles one-for-one.
- Per path: NUM_STEPS handshakes + 1 ACCUM cycle.
- With iEpsValid constantly high, oDone is high during cycle t0 + NUM_PATHS·(NUM_STEPS+1) + 1 (edge-relative).
- oAcc1/oAcc2 are final and stable in the oDone cycle.
- oEpsReady is registered-state-derived (no combinational path from iEpsValid).

## Structure
- Package mc_risk_pkg:
  - state enum
  - default FRAC and W constants
  - saturating unsigned add function
  - clamp function
- Sub-module gbm_step: combinational S_next = clamp(S+drift+diff) datapath, parameterised by W and FRAC. The top keeps the FSM, counters and accumulators.

## Test plan
- Defaults; iS=24576, iMu=0, iSigma=0, iEpsValid held 1 → oDone at t0+13; oAcc1=98304, oAcc2=589824.
- Defaults with NUM_STEPS=1; iS=24576, iMu=184, iSigma=0 → each terminal S=25680; oAcc1=102720, oAcc2=644004.
- iMu=0, iSigma=4096, iEps=-8192 → S clamps to 0 each path; oAcc1=0, oAcc2=0.
- iMu=0, iSigma=4096, iEps=4096, NUM_STEPS=3 → 24576→49152→98304→131071 (upper clamp); oAcc1=4·131071=524284.
- Case 1 with iEpsValid low for 10 cycles mid-path → results unchanged, oDone delayed by 10 cycles, no state change during stall.
- Case 1 with ACC_W=20, NUM_PATHS=8 → oAcc1=196608, oAcc2 saturates at 1048575.
- iStart pulsed while busy → ignored, results equal case 1.
- RST_N low mid-STEP → all outputs 0 immediately, IDLE. A fresh start then reproduces case 1.
